// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit (ifu_pkg).
package ifu_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [31:0] INST_NOP = 32'h00000013;
    localparam logic [31:0] PC_STEP  = 32'd4;

    // Word-align a byte address; the low two bits carry no meaning for fetch.
    function automatic logic [31:0] word_align(input logic [31:0] byte_pc);
        return {byte_pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// Fetch buffer: synchronous FIFO of {pc, inst} entries with a single-cycle flush.
// Push on full is accepted only together with a pop; flush wins over push and pop.
module fetch_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     push_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output fetch_entry_t     head
);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             full_s;
    logic             do_push_s;
    logic             do_pop_s;

    // Pointers wrap at DEPTH so non-power-of-two depths work too.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_W'(DEPTH - 1)) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = ptr + PTR_W'(1);
        end
        return nxt;
    endfunction

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        full_s    = (count_q == CNT_W'(DEPTH));
        do_push_s = push && (!full_s || pop);
        do_pop_s  = pop && (count_q != {CNT_W{1'b0}});
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; storage is cleared on reset so nothing stale is ever exposed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{pc: 32'h0, inst: 32'h0};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign empty = (count_q == {CNT_W{1'b0}});
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage in front of a 1-cycle synchronous instruction RAM, buffered to decode.
// Optional perf counters are built when FETCH_PERF_EN is defined.
module inst_fetch_unit
    import ifu_pkg::*;
#(
    parameter int          ADDR_W     = 12,
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic [ADDR_W-1:0] ram_addra,
    input  logic [31:0]       ram_douta,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [31:0]       out_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    logic [31:0]      pc_q;
    logic [31:0]      pc_d;
    logic             inflight_q;
    logic             inflight_d;
    logic [31:0]      inflight_pc_q;
    logic [31:0]      inflight_pc_d;

    logic [31:0]      issue_pc_s;
    logic             issue_s;
    logic             pop_s;
    logic [OCC_W-1:0] occ_s;
    logic             fifo_push_s;
    logic             fifo_pop_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic             fifo_empty_s;
    fetch_entry_t     fifo_head_s;
    fetch_entry_t     push_entry_s;
    logic             unused_s;

    assign unused_s = ^redirect_pc[1:0];

    // Issue credit: a read may start only if its word is guaranteed a FIFO slot.
    always_comb begin
        pop_s = (!fifo_empty_s) && out_ready;
        occ_s = OCC_W'(fifo_count_s) + OCC_W'(inflight_q) - OCC_W'(pop_s);
        if (redirect_valid) begin
            issue_pc_s = word_align(redirect_pc);
            issue_s    = 1'b1;
        end else begin
            issue_pc_s = pc_q;
            issue_s    = (occ_s < OCC_W'(FIFO_DEPTH));
        end
        if (issue_s) begin
            pc_d          = issue_pc_s + PC_STEP;
            inflight_d    = 1'b1;
            inflight_pc_d = issue_pc_s;
        end else begin
            pc_d          = pc_q;
            inflight_d    = 1'b0;
            inflight_pc_d = inflight_pc_q;
        end
        // A redirect squashes the returning word and discards any concurrent pop.
        fifo_push_s  = inflight_q && !redirect_valid;
        fifo_pop_s   = pop_s && !redirect_valid;
        push_entry_s = '{pc: inflight_pc_q, inst: ram_douta};
        ram_addra    = issue_pc_s[ADDR_W+1:2];
    end

    // PC and in-flight read tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (fifo_push_s),
        .pop       (fifo_pop_s),
        .flush     (redirect_valid),
        .push_data (push_entry_s),
        .count     (fifo_count_s),
        .empty     (fifo_empty_s),
        .head      (fifo_head_s)
    );

    // Decode sees zeros while the buffer is empty.
    always_comb begin
        out_valid = !fifo_empty_s;
        if (out_valid) begin
            out_inst = fifo_head_s.inst;
            out_pc   = fifo_head_s.pc;
        end else begin
            out_inst = 32'h0;
            out_pc   = 32'h0;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_fetch_d;
    logic [31:0] perf_flush_q;
    logic [31:0] perf_flush_d;

    // Counters only ever reset with rst; a redirect does not clear them.
    always_comb begin
        if (fifo_pop_s) begin
            perf_fetch_d = perf_fetch_q + 32'd1;
        end else begin
            perf_fetch_d = perf_fetch_q;
        end
        if (redirect_valid) begin
            perf_flush_d = perf_flush_q + 32'd1;
        end else begin
            perf_flush_d = perf_flush_q;
        end
    end

    // Perf counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_q <= 32'h0;
            perf_flush_q <= 32'h0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule
